// File: rtl/instr_fetch_queue.sv
// ----------------------------------------------------------------------------
// instr_fetch_queue
//   Instruction fetch front end between a synchronous-read code memory and the
//   decode stage. Streams sequential code words into a small prefetch FIFO,
//   tags each word with its fetch address and hands them to decode with a
//   valid/ready handshake. A jump redirects the fetch address, flushes the
//   queue and drops the read in flight.
//
//   Optional feature macro: FETCH_BYPASS_EN
//     defined   : a response arriving while the queue is empty is presented on
//                 out_* in the same cycle (and only stored if not accepted).
//     undefined : out_* come from FIFO storage only.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   mem_rd     out  code memory read strobe
//   mem_addr   out  code memory read address (valid when mem_rd=1)
//   mem_data   in   read data, valid exactly one cycle after mem_rd=1
//   jump_valid in   redirect request (single-cycle pulse)
//   jump_addr  in   redirect target
//   out_valid  out  out_word/out_pc hold a valid instruction
//   out_word   out  instruction word
//   out_pc     out  address out_word was fetched from
//   out_ready  in   decode accepts the word when out_valid & out_ready
// ----------------------------------------------------------------------------
module instr_fetch_queue #(
    parameter int                   ADDR_SIZE  = 18,
    parameter int                   WORD_SIZE  = 18,
    parameter int                   DEPTH      = 4,
    parameter logic [ADDR_SIZE-1:0] RESET_ADDR = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 mem_rd,
    output logic [ADDR_SIZE-1:0] mem_addr,
    input  logic [WORD_SIZE-1:0] mem_data,
    input  logic                 jump_valid,
    input  logic [ADDR_SIZE-1:0] jump_addr,
    output logic                 out_valid,
    output logic [WORD_SIZE-1:0] out_word,
    output logic [ADDR_SIZE-1:0] out_pc,
    input  logic                 out_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_SIZE-1:0] fetch_pc;
    logic [ADDR_SIZE-1:0] resp_pc;
    logic                 inflight;
    logic [CW-1:0]        count;
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;
    logic [WORD_SIZE-1:0] word_mem [DEPTH];
    logic [ADDR_SIZE-1:0] pc_mem   [DEPTH];

    logic fifo_valid;
    logic issue;
    logic push;
    logic pop;
    logic bypass_take;

    always_comb begin
        fifo_valid = (count != '0);
        // Credit uses the pre-pop count plus the outstanding read, so a
        // response always finds a free slot.
        issue      = !reset && !jump_valid &&
                     ((count + CW'(inflight)) < CW'(DEPTH));
        mem_rd     = issue;
        mem_addr   = fetch_pc;
`ifdef FETCH_BYPASS_EN
        out_valid   = fifo_valid || inflight;
        out_word    = fifo_valid ? word_mem[rd_ptr] : mem_data;
        out_pc      = fifo_valid ? pc_mem[rd_ptr]   : resp_pc;
        bypass_take = !fifo_valid && inflight && out_ready;
`else
        out_valid   = fifo_valid;
        out_word    = word_mem[rd_ptr];
        out_pc      = pc_mem[rd_ptr];
        bypass_take = 1'b0;
`endif
        // A jump in this cycle overrides both the handshake and the response.
        pop  = fifo_valid && out_ready && !jump_valid;
        push = inflight && !jump_valid && !bypass_take;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_ADDR;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (jump_valid) begin
            fetch_pc <= jump_addr;
            inflight <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                fetch_pc <= fetch_pc + ADDR_SIZE'(1);
                resp_pc  <= fetch_pc;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; entries are only read while count says valid.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            word_mem[wr_ptr] <= mem_data;
            pc_mem[wr_ptr]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

    localparam int AW    = 18;
    localparam int WW    = 18;
    localparam int DEPTH = 4;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_data = '0;
    logic          jump_valid = 1'b0;
    logic [AW-1:0] jump_addr = '0;
    logic          out_valid;
    logic [WW-1:0] out_word;
    logic [AW-1:0] out_pc;
    logic          out_ready = 1'b0;

    // second instance: reset address near the top of the address space
    logic          w_mem_rd;
    logic [AW-1:0] w_mem_addr;
    logic [WW-1:0] w_mem_data = '0;
    logic          w_out_valid;
    logic [WW-1:0] w_out_word;
    logic [AW-1:0] w_out_pc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    instr_fetch_queue #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .DEPTH(DEPTH), .RESET_ADDR(18'h00000)) u_dut (
        .clock(clock), .reset(reset), .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
        .jump_valid(jump_valid), .jump_addr(jump_addr), .out_valid(out_valid), .out_word(out_word),
        .out_pc(out_pc), .out_ready(out_ready));

    instr_fetch_queue #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .DEPTH(DEPTH), .RESET_ADDR(18'h3FFFE)) u_wrap (
        .clock(clock), .reset(reset), .mem_rd(w_mem_rd), .mem_addr(w_mem_addr), .mem_data(w_mem_data),
        .jump_valid(1'b0), .jump_addr(18'h00000), .out_valid(w_out_valid), .out_word(w_out_word),
        .out_pc(w_out_pc), .out_ready(1'b1));

    function automatic logic [WW-1:0] code_word(input logic [AW-1:0] a);
        return a + 18'h00100;
    endfunction

    // code memory: one-cycle read latency, junk on the bus when not answering
    always @(posedge clock) begin
        mem_data   <= mem_rd   ? code_word(mem_addr)   : WW'($urandom);
        w_mem_data <= w_mem_rd ? code_word(w_mem_addr) : WW'($urandom);
    end

    // reference model: queue of fetch addresses held for decode
    logic [AW-1:0] q[$];
    logic [AW-1:0] m_pc;
    logic [AW-1:0] m_resp_pc;
    bit            m_inflight;

    // values sampled in the current step
    logic          s_rd, s_valid, w_valid_s;
    logic [AW-1:0] s_pc, w_pc_s;
    logic [WW-1:0] w_word_s;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_pc       = 18'h00000;
        m_inflight = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset      = 1'b1;
        jump_valid = 1'b0;
        @(posedge clock);
        #1;
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic step(input bit jv, input logic [AW-1:0] ja, input bit rdy);
        bit            e_rd, e_valid, acc;
        logic [AW-1:0] e_pc;
        int            sz;
        @(negedge clock);
        jump_valid = jv;
        jump_addr  = ja;
        out_ready  = rdy;
        #1;
        sz      = q.size();
        e_rd    = !jv && ((sz + int'(m_inflight)) < DEPTH);
        e_valid = (sz > 0) || (BYP && m_inflight);
        e_pc    = (sz > 0) ? q[0] : m_resp_pc;
        check("mem_rd", mem_rd, e_rd);
        if (e_rd) check("mem_addr", mem_addr, m_pc);
        check("out_valid", out_valid, e_valid);
        if (e_valid) begin
            check("out_pc", out_pc, e_pc);
            check("out_word", out_word, code_word(e_pc));
        end
        s_rd = mem_rd; s_valid = out_valid; s_pc = out_pc;
        w_valid_s = w_out_valid; w_pc_s = w_out_pc; w_word_s = w_out_word;
        @(posedge clock);
        if (jv) begin
            q.delete();
            m_pc       = ja;
            m_inflight = 1'b0;
        end else begin
            acc = e_valid && rdy;
            if (acc && sz > 0) void'(q.pop_front());
            if (m_inflight && !(acc && sz == 0)) q.push_back(m_resp_pc);
            m_inflight = e_rd;
            if (e_rd) begin
                m_resp_pc = m_pc;
                m_pc      = m_pc + 18'h00001;
            end
        end
    endtask

    initial begin : main
        logic [AW-1:0] exp4 [4];
        int k, first, reads;
        bit reached, found;

        exp4[0] = 18'h3FFFE; exp4[1] = 18'h3FFFF; exp4[2] = 18'h00000; exp4[3] = 18'h00001;
        m_resp_pc = '0;

        // streaming after reset, and wraparound on the second instance
        do_reset();
        k = 0; first = -1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, '0, 1'b1);
            if (w_valid_s && k < 4) begin
                if (first < 0) first = i + 1;
                check("wrap_pc", w_pc_s, exp4[k]);
                check("wrap_word", w_word_s, code_word(exp4[k]));
                k++;
            end
        end
        check("wrap_first_cycle", first, BYP ? 2 : 3);
        check("wrap_words_seen", k, 4);

        // backpressure: exactly DEPTH reads, then drain in order
        do_reset();
        reads = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, '0, 1'b0);
            if (s_rd) reads++;
        end
        check("bp_reads", reads, DEPTH);
        check("bp_head_pc", s_pc, 18'h00000);
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);

        // jump with 3 queued words and a read in flight
        do_reset();
        reached = 1'b0;
        for (int i = 0; i < 10 && !reached; i++) begin
            step(1'b0, '0, 1'b0);
            reached = (q.size() == 3) && m_inflight;
        end
        check("t3_setup", reached, 1'b1);
        step(1'b1, 18'h00200, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step(1'b0, '0, 1'b1);
            if (s_valid) begin
                found = 1'b1;
                check("t3_first_pc", s_pc, 18'h00200);
            end
        end
        check("t3_found", found, 1'b1);

        // jump coinciding with pop and push
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 18'h00300, 1'b1);
        step(1'b0, '0, 1'b1);
        check("t5_empty", s_valid, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            step(1'b0, '0, 1'b1);
            if (s_valid) begin
                found = 1'b1;
                check("t5_first_pc", s_pc, 18'h00300);
            end
        end
        check("t5_found", found, 1'b1);

        // two consecutive jumps: last one wins
        step(1'b1, 18'h00010, 1'b1);
        step(1'b1, 18'h00020, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            step(1'b0, '0, 1'b1);
            if (s_valid) begin
                found = 1'b1;
                check("t5b_first_pc", s_pc, 18'h00020);
            end
        end
        check("t5b_found", found, 1'b1);

        // post-jump latency
        step(1'b1, 18'h00040, 1'b0);
        step(1'b0, '0, 1'b0);
        check("t6_n1_valid", s_valid, 1'b0);
        step(1'b0, '0, 1'b0);
        check("t6_n2_valid", s_valid, BYP);
        step(1'b0, '0, 1'b0);
        check("t6_n3_valid", s_valid, 1'b1);
        check("t6_n3_pc", s_pc, 18'h00040);

        // randomized traffic with occasional jumps and a mid-run reset
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            if ($urandom_range(19) == 0)
                step(1'b1, ($urandom_range(1) == 0) ? AW'($urandom) : 18'h3FFFD, $urandom_range(9) < 7);
            else
                step(1'b0, AW'($urandom), $urandom_range(9) < 7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
